// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the single-port BRAM arbiter.
//   MAX_REQ : largest supported requester count
//   IDX_W   : width of a requester index
//   pick_t  : result of a round-robin search (found flag + index)
//   rr_pick : first set bit of valid at or after ptr, wrapping modulo n
package bram_arb_pkg;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scan from the farthest offset down to offset 0 so the closest hit to ptr
  // is the last one written and therefore wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 n);
    pick_t p;
    int    k;
    p = '0;
    for (int i = MAX_REQ-1; i >= 0; i--) begin
      k = (int'(ptr) + i) % n;
      if (i < n && valid[k[IDX_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = k[IDX_W-1:0];
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk_i, rst_i : clock, async active-high reset
//   valid_i      : per-requester request
//   grant_o      : one-hot grant (zero when idle or in reset)
//   gnt_any_o    : a grant is issued this cycle
//   gnt_idx_o    : index of the granted requester
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               gnt_any_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);
  logic [IDX_W-1:0]   r_ptr;
  logic [MAX_REQ-1:0] w_valid;
  pick_t              w_pick;

  always_comb begin
    w_valid                = '0;
    w_valid[NUM_REQ-1:0]   = valid_i;
    w_pick                 = rr_pick(w_valid, r_ptr, NUM_REQ);
    gnt_any_o              = w_pick.found & ~rst_i;
    gnt_idx_o              = w_pick.idx;
    grant_o                = gnt_any_o ? (NUM_REQ'(1) << w_pick.idx) : '0;
  end

  // Pointer moves just past the winner so it has lowest priority next time.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_ptr <= '0;
    else if (gnt_any_o) begin
      if (w_pick.idx == IDX_W'(NUM_REQ-1)) r_ptr <= '0;
      else                                 r_ptr <= w_pick.idx + 1'b1;
    end
  end
endmodule

// File: rtl/bram_1p_arbiter.sv
// Shares one single-port, no-change-mode synchronous BRAM among NUM_REQ
// requesters. One access granted per cycle; read data (1-cycle latency) is
// steered back to the requester that issued the read.
//   clk_i, rst_i  : clock, async active-high reset
//   req_*         : per-requester valid/ready/we and flattened addr/wdata
//   rsp_valid_o   : one-hot read-response pulse
//   rsp_rdata_o   : read data, pass-through of ram_rdata_i
//   ram_*         : BRAM drive and registered read data
module bram_1p_arbiter
  import bram_arb_pkg::*;
#(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10,
  parameter int NUM_REQ       = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0]               req_we_i,
  input  logic [NUM_REQ*RAM_ADDR_BITS-1:0] req_addr_i,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]     req_wdata_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  output logic [RAM_WIDTH-1:0]             rsp_rdata_o,
  output logic                             ram_en_o,
  output logic                             ram_we_o,
  output logic [RAM_ADDR_BITS-1:0]         ram_addr_o,
  output logic [RAM_WIDTH-1:0]             ram_wdata_o,
  input  logic [RAM_WIDTH-1:0]             ram_rdata_i
);
  logic [NUM_REQ-1:0] w_grant;
  logic               w_gnt_any;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_rd;
  logic               r_rsp_pend;
  logic [IDX_W-1:0]   r_rsp_owner;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (req_valid_i),
    .grant_o   (w_grant),
    .gnt_any_o (w_gnt_any),
    .gnt_idx_o (w_gnt_idx)
  );

  assign req_ready_o = w_grant;

  // One-hot mux onto the RAM port; everything is zero when nothing is granted.
  always_comb begin
    ram_en_o    = w_gnt_any;
    ram_we_o    = |(req_we_i & w_grant);
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        ram_addr_o  = req_addr_i[k*RAM_ADDR_BITS +: RAM_ADDR_BITS];
        ram_wdata_o = req_wdata_i[k*RAM_WIDTH +: RAM_WIDTH];
      end
    end
  end

  assign w_rd = w_gnt_any & ~ram_we_o;

  // Reset clears the pending flag asynchronously, so an in-flight response
  // disappears immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_pend  <= 1'b0;
      r_rsp_owner <= '0;
    end else begin
      r_rsp_pend <= w_rd;
      if (w_rd) r_rsp_owner <= w_gnt_idx;
    end
  end

  // No-change BRAM holds its output across a following write, so the data
  // can be passed straight through.
  assign rsp_valid_o = r_rsp_pend ? (NUM_REQ'(1) << r_rsp_owner) : '0;
  assign rsp_rdata_o = ram_rdata_i;
endmodule

// File: doc/bram_1p_arbiter.md
Name: bram_1p_arbiter

Overview:
- Round-robin arbiter sharing one single-port, no-change-mode synchronous BRAM among NUM_REQ requesters.
- Each cycle it grants at most one read or write request and drives the BRAM enable, write-enable, address and data.
- It routes the 1-cycle-latency read data back to the requester that issued the read.
- Sits between client blocks (DMA, CPU load/store, debug port) and the BRAM primitive, which is outside this block.

Parameters:
- RAM_WIDTH, 8, data word width in bits.
- RAM_ADDR_BITS, 10, address width in bits.
- NUM_REQ, 2, number of requesters; legal range 2..8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_we_i  in  NUM_REQ  1 = write, 0 = read.
- req_addr_i  in  NUM_REQ*RAM_ADDR_BITS  flattened addresses; requester k uses bits [k*RAM_ADDR_BITS +: RAM_ADDR_BITS].
- req_wdata_i  in  NUM_REQ*RAM_WIDTH  flattened write data; same slicing rule.
- rsp_valid_o  out  NUM_REQ  one-cycle read-response pulse, one-hot or zero.
- rsp_rdata_o  out  RAM_WIDTH  read data; meaningful only while any rsp_valid_o bit is 1.
- ram_en_o  out  1  BRAM enable.
- ram_we_o  out  1  BRAM write enable.
- ram_addr_o  out  RAM_ADDR_BITS  BRAM address.
- ram_wdata_o  out  RAM_WIDTH  BRAM write data.
- ram_rdata_i  in  RAM_WIDTH  BRAM registered read data, valid 1 cycle after a read-enable.

Behaviour:
- Reset values: rsp_valid_o = 0, priority pointer = 0 (requester 0 highest priority), last-read-owner = 0, response-pending = 0.
- Combinational outputs while rst_i = 1: req_ready_o = 0, ram_en_o = 0, ram_we_o = 0.
- Arbitration is combinational in the request cycle:
  - Search req_valid_i starting at index ptr and wrapping modulo NUM_REQ; the first set bit g is granted.
  - req_ready_o[g] = 1 and all other ready bits are 0.
  - Handshake completes when valid & ready are both 1 in the same cycle.
  - ready never waits on anything except the arbitration; there is no bubble between back-to-back grants.
- On a grant:
  - ram_en_o = 1, ram_we_o = req_we_i[g].
  - ram_addr_o and ram_wdata_o take requester g's slices.
  - On the next clock edge, ptr <= (g+1) mod NUM_REQ.
- With no valid request:
  - ram_en_o = 0 and ptr holds.
  - ram_addr_o, ram_wdata_o and ram_we_o are driven 0.
- Requester rule: once req_valid_i is raised, address, data and we must stay stable until ready. The arbiter itself does not check this.
- Read response:
  - A granted read sets the response-pending flag and the read owner g on the clock edge.
  - In the next cycle, rsp_valid_o[owner] = 1 and rsp_rdata_o = ram_rdata_i (pass-through, no extra register).
  - Read latency, request handshake to response: exactly 1 cycle.
  - There is no response backpressure; the requester must accept.
- Writes produce no response.
- No-change mode: a write in the cycle after a read does not disturb the response, because the BRAM output holds. rsp_rdata_o is therefore valid even when a write is granted in the response cycle.
- Throughput is one access per cycle; reads and writes may interleave freely.
- Response for read N and grant for access N+1 occur in the same cycle.
- Same-address read after write returns the new data. Write then read are separate cycles, so there is no hazard.
- Single requester valid continuously: granted every cycle; ptr advances past it but the search wraps back to it.
- All requesters valid: strict rotation 0, 1, ..., NUM_REQ-1, 0, ...
- Asynchronous reset mid-operation:
  - An in-flight read response is dropped; rsp_valid_o is 0 immediately.
  - ptr returns to 0.
  - The requester must reissue the read after reset.

Decomposition:
- Package bram_arb_pkg holds:
  - localparam MAX_REQ = 8;
  - a function rr_pick(valid, ptr) returning the grant index plus a found flag, with wrap handled generically.
- One natural sub-module: rr_arbiter. It has NUM_REQ-wide valid in, one-hot grant out, the registered pointer, and clk_i/rst_i.
- bram_1p_arbiter instantiates rr_arbiter and adds the mux, the response tracking and the RAM drive.

Test Plan:
- Reset: assert rst_i mid-cycle with a read pending -> rsp_valid_o = 0 at once, ram_en_o = 0, first grant after reset goes to requester 0 when all are valid.
- Single write then read, NUM_REQ=2: req0 writes 0xA5 to 0x010, then reads 0x010 -> ram_en_o=1, ram_we_o=1, then rsp_valid_o=2'b01 one cycle after the read with rsp_rdata_o=0xA5.
- Contention: both valid every cycle, both reading addresses 0x001 and 0x002 preloaded with 0x11 and 0x22 -> grants alternate 0,1,0,1; responses alternate 0x11 to req0 and 0x22 to req1, each 1 cycle after its grant.
- Read followed by write in the next cycle from the other requester -> response data still equals the read value (no-change); the write lands.
- Pointer wrap, NUM_REQ=4: only req3 and req0 valid, ptr=3 -> grant 3, then 0, then 3; ready is always one-hot.
- Idle gap: no valid for 5 cycles -> ram_en_o=0 throughout, ptr unchanged, no rsp_valid_o pulses.
